oa_tile_accumulator: RTL
========================

// Module: oa_tile_accumulator
// PURPOSE
// - Downstream of the bias loader. Accumulates SIZE-lane partial-sum rows from the compute core into an
//   OA-tile buffer of up to SIZE rows x SIZE lanes.
// - Seeds each lane with the bias vector on the first partial sum of an OA tile, and adds on every later one.
// - After the last partial sum, drains the finished OA tile row by row over a valid/ready stream.
// - Generates the partial_sum_calc_over and tile_calc_over pulses consumed by the bias loader.
// PARAMETERS
// - SIZE       16  lanes per row; also the maximum number of rows per OA tile.
// - DATA_WIDTH 32  width of each psum, bias and accumulator lane (two's complement).
// - RW         $clog2(SIZE+1)  row-count width (localparam).
// PORTS
// - clk                    in   1              clock
// - rst_n                  in   1              reset, asynchronous, active-low
// - init_cfg               in   1              latch cfg_rows; abort any run
// - cfg_rows               in   RW             rows per OA tile, 1..SIZE; 0 or >SIZE means SIZE
// - tile_calc_start        in   1              start a partial-sum run (level; rising edge used)
// - ps_first               in   1              sampled at start edge: first partial sum of the OA tile
// - ps_last                in   1              sampled at start edge: last partial sum of the OA tile
// - bias_in[SIZE]          in   DATA_WIDTH     bias vector (bias loader data_out)
// - psum_valid             in   1              psum row valid
// - psum_data[SIZE]        in   DATA_WIDTH     psum row; rows arrive in order 0..cfg_rows-1
// - psum_ready             out  1              accumulator accepts a psum row
// - partial_sum_calc_over  out  1              1-cycle pulse: run finished accepting rows
// - tile_calc_over         out  1              1-cycle pulse: OA tile fully drained
// - oa_valid               out  1              output row valid
// - oa_data[SIZE]          out  DATA_WIDTH     output row (accumulator contents)
// - oa_row                 out  RW             index of the output row
// - oa_ready               in   1              downstream accepts the output row
// - busy                   out  1              state != IDLE
// - protocol_err           out  1              sticky error; cleared by init_cfg
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; cfg_rows latched as SIZE; accumulator contents don't-care.
// - start_pulse = tile_calc_start & ~tile_calc_start_d (registered edge detect).
// - FSM:
//   - IDLE: on start_pulse, latch ps_first/ps_last, clear row_cnt, go to BWAIT.
//   - BWAIT: exactly 2 cycles while bias_in settles; psum_ready=0. Then go to ACCUM.
//   - ACCUM: psum_ready=1. Each psum_valid&psum_ready beat writes row row_cnt, lane j:
//     - acc = bias_in[j] + psum_data[j] when first=1;
//     - acc = acc + psum_data[j] otherwise.
//     - row_cnt increments.
//     - On the beat with row_cnt==cfg_rows-1: the next cycle pulses partial_sum_calc_over and goes
//       to DRAIN if last=1, else to IDLE.
//   - DRAIN: oa_valid=1, oa_data=acc[row_cnt], oa_row=row_cnt (row_cnt restarts at 0 on entry).
//     - oa_valid/oa_data/oa_row hold stable until oa_ready.
//     - On the handshake of row cfg_rows-1: the next cycle pulses tile_calc_over and goes to IDLE.
// - Latency: first psum accepted no earlier than 3 cycles after the start edge. oa_valid rises 1 cycle
//   after the partial_sum_calc_over pulse.
// - Addition: DATA_WIDTH modulo (wrap) unless OA_ACC_SAT_EN is defined.
// - Boundary and error conditions:
//   - start_pulse outside IDLE: ignored; set protocol_err.
//   - ps_first=0 on the first run after init_cfg or after a drain: accumulate anyway; set protocol_err.
//   - psum_valid in IDLE, BWAIT or DRAIN: not accepted; no error.
//   - init_cfg in any state: go to IDLE; row_cnt=0; oa_valid=0; no pulses. init_cfg wins over a
//     simultaneous start_pulse.
//   - cfg_rows=1: a single beat completes the run.
//   - Back-to-back: a start_pulse in the IDLE cycle right after a pulse is accepted.
// CONFIGURATION
// - OA_ACC_SAT_EN defined: each lane add saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
// - OA_ACC_SAT_EN undefined: plain wrap-around add, no overflow detection.
// TESTING
// - T1 bias seed: SIZE=4, cfg_rows=2, ps_first=ps_last=1, bias={1,2,3,4}, psum rows {10,10,10,10},{0,0,0,0}
//   -> oa row0={11,12,13,14}, row1={1,2,3,4}; one pulse each of partial_sum_calc_over and tile_calc_over.
// - T2 accumulation: 3 runs (first, mid, last), psum all 5, bias all 7 -> every lane 22; psco pulses 3x,
//   tile_calc_over 1x.
// - T3 backpressure: hold oa_ready=0 for 5 cycles in DRAIN -> oa_data/oa_row stable; no tile_calc_over
//   until all rows have handshaken.
// - T4 overflow: acc=0x7FFFFFFF, psum=1 -> 0x80000000 without OA_ACC_SAT_EN; 0x7FFFFFFF with it.
// - T5 errors: start edge while in ACCUM -> protocol_err=1, state unchanged. init_cfg mid-DRAIN ->
//   IDLE next cycle, oa_valid=0, protocol_err=0.
// - T6 BWAIT timing: psum_valid held high from the start edge -> psum_ready low for exactly 2 cycles
//   after the edge detect, then accepts.

Source files
------------

// File: rtl/oa_tile_accumulator.sv
// OA-tile accumulator: seeds rows with bias, accumulates partial-sum rows, then drains the tile row by row.
// Build option: define OA_ACC_SAT_EN for saturating lane adds; without it lane adds wrap.
module oa_tile_accumulator #(
  parameter int SIZE = 16,
  parameter int DATA_WIDTH = 32,
  localparam int RW = $clog2(SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_cfg,
  input  logic [RW-1:0]         cfg_rows,
  input  logic                  tile_calc_start,
  input  logic                  ps_first,
  input  logic                  ps_last,
  input  logic [DATA_WIDTH-1:0] bias_in [SIZE],
  input  logic                  psum_valid,
  input  logic [DATA_WIDTH-1:0] psum_data [SIZE],
  output logic                  psum_ready,
  output logic                  partial_sum_calc_over,
  output logic                  tile_calc_over,
  output logic                  oa_valid,
  output logic [DATA_WIDTH-1:0] oa_data [SIZE],
  output logic [RW-1:0]         oa_row,
  input  logic                  oa_ready,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [RW-1:0] SIZE_RW = RW'(SIZE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BWAIT  = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_PSDONE = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_TDONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  start_dly_q, start_dly_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  need_first_q, need_first_d;
  logic                  err_q, err_d;
  logic                  bw_cnt_q, bw_cnt_d;
  logic [RW-1:0]         rows_q, rows_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] acc_d [SIZE][SIZE];
  logic                  start_pulse;
  logic [RW-1:0]         last_row;
  logic [IW-1:0]         row_idx;

  function automatic logic [DATA_WIDTH-1:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef OA_ACC_SAT_EN
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign start_pulse = tile_calc_start & ~start_dly_q;
  assign last_row    = rows_q - RW'(1);
  assign row_idx     = row_cnt_q[IW-1:0];

  // Both streams use plain valid/ready: a beat transfers on a cycle where valid and ready are both 1;
  // the sender holds valid and data stable until that cycle.
  assign psum_ready            = (state_q == S_ACCUM);
  assign partial_sum_calc_over = (state_q == S_PSDONE);
  assign tile_calc_over        = (state_q == S_TDONE);
  assign oa_valid              = (state_q == S_DRAIN);
  assign oa_row                = oa_valid ? row_cnt_q : '0;
  assign busy                  = (state_q != S_IDLE);
  assign protocol_err          = err_q;

  always_comb begin
    for (int j = 0; j < SIZE; j++) oa_data[j] = oa_valid ? acc_q[row_idx][j] : '0;
  end

  always_comb begin
    state_d      = state_q;
    start_dly_d  = tile_calc_start;
    first_d      = first_q;
    last_d       = last_q;
    need_first_d = need_first_q;
    err_d        = err_q;
    bw_cnt_d     = bw_cnt_q;
    rows_d       = rows_q;
    row_cnt_d    = row_cnt_q;
    acc_d        = acc_q;
    if (init_cfg) begin
      state_d      = S_IDLE;
      row_cnt_d    = '0;
      bw_cnt_d     = 1'b0;
      need_first_d = 1'b1;
      err_d        = 1'b0;
      rows_d       = (cfg_rows == '0 || cfg_rows > SIZE_RW) ? SIZE_RW : cfg_rows;
    end else begin
      if (start_pulse && state_q != S_IDLE) err_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            first_d      = ps_first;
            last_d       = ps_last;
            row_cnt_d    = '0;
            bw_cnt_d     = 1'b0;
            state_d      = S_BWAIT;
            need_first_d = 1'b0;
            if (need_first_q && !ps_first) err_d = 1'b1;
          end
        end
        // Two cycles with psum_ready low so bias_in has settled before the seeding beat.
        S_BWAIT: begin
          bw_cnt_d = 1'b1;
          if (bw_cnt_q) state_d = S_ACCUM;
        end
        S_ACCUM: begin
          if (psum_valid) begin
            for (int j = 0; j < SIZE; j++)
              acc_d[row_idx][j] = lane_add(first_q ? bias_in[j] : acc_q[row_idx][j], psum_data[j]);
            row_cnt_d = row_cnt_q + RW'(1);
            if (row_cnt_q == last_row) state_d = S_PSDONE;
          end
        end
        S_PSDONE: begin
          row_cnt_d = '0;
          state_d   = last_q ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (oa_ready) begin
            row_cnt_d = row_cnt_q + RW'(1);
            if (row_cnt_q == last_row) state_d = S_TDONE;
          end
        end
        S_TDONE: begin
          row_cnt_d    = '0;
          need_first_d = 1'b1;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_dly_q  <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      need_first_q <= 1'b1;
      err_q        <= 1'b0;
      bw_cnt_q     <= 1'b0;
      rows_q       <= SIZE_RW;
      row_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_dly_q  <= start_dly_d;
      first_q      <= first_d;
      last_q       <= last_d;
      need_first_q <= need_first_d;
      err_q        <= err_d;
      bw_cnt_q     <= bw_cnt_d;
      rows_q       <= rows_d;
      row_cnt_q    <= row_cnt_d;
    end
  end

  // Tile storage needs no reset: every row is written by a seeding beat before it is drained.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule
